// File: rtl/vc_switch_allocator_pkg.sv
// Shared NoC router definitions: arbitration modes, allocator FSM states, one-hot helper.
// Pure declarations; no latency or backpressure of its own.
package noc_router_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic {
        VSA_IDLE   = 1'b0,
        VSA_LOCKED = 1'b1
    } vsa_state_t;

    function automatic int onehot_to_idx(input logic [31:0] onehot);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (onehot[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/vc_switch_allocator_if.sv
// VC allocator port bundle: VC front-of-buffer status in, pop strobe and credit state out.
// Wires only; master is the VC buffer/link side, slave is the allocator.
interface vc_switch_allocator_if #(
    parameter int NUM_VC       = 4,
    parameter int CREDIT_DEPTH = 4
);
    localparam int VC_W  = $clog2(NUM_VC);
    localparam int CNT_W = $clog2(CREDIT_DEPTH + 1);

    logic [NUM_VC-1:0]       vc_valid;
    logic [NUM_VC-1:0]       vc_head;
    logic [NUM_VC-1:0]       vc_tail;
    logic                    out_ready;
    logic [NUM_VC-1:0]       credit_return;
    logic [NUM_VC-1:0]       grant_onehot;
    logic [VC_W-1:0]         selected_vc;
    logic                    locked;
    logic [NUM_VC*CNT_W-1:0] credit_cnt;
    logic                    credit_err;

    modport master (
        output vc_valid, vc_head, vc_tail, out_ready, credit_return,
        input  grant_onehot, selected_vc, locked, credit_cnt, credit_err
    );

    modport slave (
        input  vc_valid, vc_head, vc_tail, out_ready, credit_return,
        output grant_onehot, selected_vc, locked, credit_cnt, credit_err
    );

endinterface

// File: rtl/vc_switch_allocator_rr_pick.sv
// One-hot request picker: round-robin starting after ptr, or fixed lowest-index priority.
// Purely combinational; no backpressure.
module rr_pick
    import noc_router_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = ARB_RR,
    localparam int PW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    always_comb begin
        int   idx;
        logic found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            // Round-robin scans ptr+1, ptr+2, ... so the last winner goes to the back.
            if (MODE == ARB_FIXED) idx = k;
            else                   idx = (int'(ptr) + 1 + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_switch_allocator.sv
// Per-output-port VC arbiter with packet locking and per-VC downstream credit counters.
// Latency: 1-cycle arbitration, then one flit per cycle; stalls on missing valid, credit or out_ready.
module vc_switch_allocator
    import noc_router_pkg::*;
#(
    parameter int NUM_VC       = 4,
    parameter int CREDIT_DEPTH = 4,
    parameter int ARB_MODE     = ARB_RR
) (
    input  logic                 clk,
    input  logic                 reset,
    vc_switch_allocator_if.slave bus
);

    localparam int VC_W  = $clog2(NUM_VC);
    localparam int CNT_W = $clog2(CREDIT_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDIT_DEPTH);

    vsa_state_t        state, state_nxt;
    logic [VC_W-1:0]   sel_q;
    logic [VC_W-1:0]   rr_ptr;
    logic [NUM_VC-1:0] has_credit;
    logic [NUM_VC-1:0] eligible;
    logic [NUM_VC-1:0] pick_gnt;
    logic [NUM_VC-1:0] grant;
    logic [NUM_VC-1:0] overflow;
    logic              fire;
    logic              err_q;

    // Only packet heads compete; body flits are reachable solely through the lock.
    assign eligible = bus.vc_valid & bus.vc_head & has_credit;

    rr_pick #(
        .N    (NUM_VC),
        .MODE (ARB_MODE)
    ) u_pick (
        .req (eligible),
        .ptr (rr_ptr),
        .gnt (pick_gnt)
    );

    always_comb begin
        state_nxt = state;
        fire      = 1'b0;
        grant     = '0;
        case (state)
            VSA_IDLE: begin
                if (|eligible) state_nxt = VSA_LOCKED;
            end
            VSA_LOCKED: begin
                fire         = bus.vc_valid[sel_q] & has_credit[sel_q] & bus.out_ready;
                grant[sel_q] = fire;
                if (fire && bus.vc_tail[sel_q]) state_nxt = VSA_IDLE;
            end
            default: state_nxt = VSA_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= VSA_IDLE;
            sel_q  <= '0;
            rr_ptr <= VC_W'(NUM_VC - 1);
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == VSA_IDLE && |eligible)
                sel_q <= VC_W'(onehot_to_idx(32'(pick_gnt)));
            if (fire && bus.vc_tail[sel_q])
                rr_ptr <= sel_q;
            if (|overflow)
                err_q <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_VC; i++) begin : g_credit
        logic [CNT_W-1:0] cnt_q;
        logic             inc;
        logic             dec;

        assign inc           = bus.credit_return[i];
        assign dec           = grant[i];
        assign has_credit[i] = (cnt_q != '0);
        // A return that would exceed the downstream buffer size means the peer lost count.
        assign overflow[i]   = inc & ~dec & (cnt_q == CNT_MAX);
        assign bus.credit_cnt[i*CNT_W +: CNT_W] = cnt_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                cnt_q <= CNT_MAX;
            else if (inc && !dec && cnt_q != CNT_MAX)
                cnt_q <= cnt_q + 1'b1;
            else if (dec && !inc)
                cnt_q <= cnt_q - 1'b1;
        end
    end

    assign bus.grant_onehot = grant;
    assign bus.selected_vc  = sel_q;
    assign bus.locked       = (state == VSA_LOCKED);
    assign bus.credit_err   = err_q;

endmodule
